ram_byte_lane_sp: RTL

- Parametrised byte-addressable single-port data memory for the MIPS datapath MEM stage; successor to the word-only asynchronous RAM.
- Supports byte/halfword/word stores with lane enables, and sign- or zero-extended loads, matching MIPS lb/lbu/lh/lhu/lw/sb/sh/sw.
- Adds a hardware clear sequencer, misalignment detection and an independent asynchronous debug read port for the debug unit.

---
 rtl/ram_byte_lane_sp.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ram_byte_lane_sp.sv
// Byte-addressable single-port data memory for the MEM stage: lane-masked stores, extended loads,
// clear sequencer, sticky misalignment flag and debug read port. RAM_BIG_ENDIAN_EN selects big-endian lanes.
module ram_byte_lane_sp #(
  parameter int NB_WIDTH = 32,
  parameter int NB_DATA  = 8,
  parameter int NB_ADDR  = 9
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_clear,
  input  logic                i_we,
  input  logic [1:0]          i_size,
  input  logic                i_unsigned,
  input  logic [NB_ADDR-1:0]  i_addr,
  input  logic [NB_WIDTH-1:0] i_data_in,
  output logic [NB_WIDTH-1:0] o_data_out,
  input  logic [NB_ADDR-3:0]  i_dbg_addr,
  output logic [NB_WIDTH-1:0] o_dbg_data,
  output logic                o_busy,
  output logic                o_misaligned
);

  localparam int NB_WADDR = NB_ADDR - 2;
  localparam int N_WORDS  = 2 ** NB_WADDR;
  localparam logic [NB_WADDR-1:0] LAST_WORD = {NB_WADDR{1'b1}};

  typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

  state_t                r_state;
  logic [NB_WADDR-1:0]   r_cnt;
  logic                  r_busy;
  logic                  r_misaligned;
  logic [NB_WIDTH-1:0]   r_mem [N_WORDS];

  logic [NB_WADDR-1:0]   w_widx;
  logic [NB_WIDTH-1:0]   w_word;
  logic                  w_aligned;
  logic                  w_do_write;
  logic [3:0]            w_lane_log;
  logic [3:0]            w_lane_en;
  logic [1:0]            w_byte_sel;
  logic                  w_half_hi;
  logic [NB_WIDTH-1:0]   w_wdata;
  logic [NB_WIDTH-1:0]   w_merged;
  logic [NB_DATA-1:0]    w_byte;
  logic [2*NB_DATA-1:0]  w_half;

  assign w_widx     = i_addr[NB_ADDR-1:2];
  assign w_word     = r_mem[w_widx];
  assign w_do_write = (r_state == ST_IDLE) && i_we && w_aligned;
  assign o_dbg_data = r_mem[i_dbg_addr];
  assign o_busy       = r_busy;
  assign o_misaligned = r_misaligned;

  // Lane-to-bit placement; the store data stays right-justified in both modes.
`ifdef RAM_BIG_ENDIAN_EN
  assign w_lane_en  = {w_lane_log[0], w_lane_log[1], w_lane_log[2], w_lane_log[3]};
  assign w_byte_sel = ~i_addr[1:0];
  assign w_half_hi  = ~i_addr[1];
`else
  assign w_lane_en  = w_lane_log;
  assign w_byte_sel = i_addr[1:0];
  assign w_half_hi  = i_addr[1];
`endif

  // Alignment check, logical lane enables and replicated store data for the access size.
  always_comb begin
    w_aligned  = 1'b1;
    w_lane_log = 4'b1111;
    w_wdata    = i_data_in;
    case (i_size)
      2'b00: begin
        w_aligned  = 1'b1;
        w_lane_log = 4'b0001 << i_addr[1:0];
        w_wdata    = {4{i_data_in[NB_DATA-1:0]}};
      end
      2'b01: begin
        w_aligned  = ~i_addr[0];
        w_lane_log = i_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata    = {2{i_data_in[2*NB_DATA-1:0]}};
      end
      default: begin
        w_aligned  = (i_addr[1:0] == 2'b00);
        w_lane_log = 4'b1111;
        w_wdata    = i_data_in;
      end
    endcase
  end

  // Merge the store into the current word so only enabled lanes change.
  always_comb begin
    w_merged = w_word;
    for (int l = 0; l < 4; l++) begin
      if (w_lane_en[l]) begin
        w_merged[l*NB_DATA +: NB_DATA] = w_wdata[l*NB_DATA +: NB_DATA];
      end else begin
        w_merged[l*NB_DATA +: NB_DATA] = w_word[l*NB_DATA +: NB_DATA];
      end
    end
  end

  // Byte and halfword selection from the addressed word.
  always_comb begin
    case (w_byte_sel)
      2'd0:    w_byte = w_word[NB_DATA-1:0];
      2'd1:    w_byte = w_word[2*NB_DATA-1:NB_DATA];
      2'd2:    w_byte = w_word[3*NB_DATA-1:2*NB_DATA];
      default: w_byte = w_word[4*NB_DATA-1:3*NB_DATA];
    endcase
    if (w_half_hi) begin
      w_half = w_word[NB_WIDTH-1 -: 2*NB_DATA];
    end else begin
      w_half = w_word[2*NB_DATA-1:0];
    end
  end

  // Load path: zero while clearing or misaligned, otherwise extended per size.
  always_comb begin
    o_data_out = '0;
    if ((r_state != ST_IDLE) || !w_aligned) begin
      o_data_out = '0;
    end else begin
      case (i_size)
        2'b00:   o_data_out = {{(NB_WIDTH-NB_DATA){w_byte[NB_DATA-1] & ~i_unsigned}}, w_byte};
        2'b01:   o_data_out = {{(NB_WIDTH-2*NB_DATA){w_half[2*NB_DATA-1] & ~i_unsigned}}, w_half};
        default: o_data_out = w_word;
      endcase
    end
  end

  // Storage array: the clear sequencer owns the port while active.
  always_ff @(posedge i_clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_cnt] <= '0;
    end else if (w_do_write) begin
      r_mem[w_widx] <= w_merged;
    end
  end

  // Clear sequencer and sticky misalignment flag.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= ST_CLEAR;
      r_cnt        <= '0;
      r_busy       <= 1'b1;
      r_misaligned <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_cnt == LAST_WORD) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + {{(NB_WADDR-1){1'b0}}, 1'b1};
          end
        end
        ST_IDLE: begin
          if (i_clear) begin
            r_state      <= ST_CLEAR;
            r_cnt        <= '0;
            r_busy       <= 1'b1;
            r_misaligned <= 1'b0;
          end else if (!w_aligned) begin
            r_misaligned <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_CLEAR;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule
